// File: rtl/nios_cpu_index_pkg.sv
// Shared definitions for the Nios index capture path.
// Contents: capture FSM state type, default index width and default
// synchronizer depth.
package nios_cpu_index_pkg;

  localparam int INDEX_WIDTH               = 8;
  localparam int INDEX_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HOLD    = 2'd2
  } index_state_t;

endpackage

// File: rtl/nios_cpu_sync_bit.sv
// Single-bit multi-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears every stage
//   d       - asynchronous input bit
//   q       - synchronized output, taken from the last stage
// STAGES is the chain depth; 2..4 is the supported range.
module nios_cpu_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/nios_cpu_index_capture.sv
// Captures an 8-bit index from an asynchronous 4-phase req/ack source and
// holds it stable for the Nios index PIO input port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request pending, src_ack low
// QUALIFY | synchronized request seen for one cycle; must still be high
//         | on the next edge to be captured, otherwise it is a glitch
// HOLD    | index captured, src_ack high until the request drops
//
// Ports:
//   clk, reset_n   - system clock, asynchronous active-low reset
//   src_req        - asynchronous request (level, 4-phase)
//   src_data       - index value, stable while the request is pending
//   src_ack        - registered acknowledge back to the source
//   index_out      - last captured index, feeds the PIO in_port
//   index_updated  - one-cycle pulse when index_out takes a new value
//   capture_count  - wrapping count of completed captures
//   glitch_seen    - sticky flag, set when a qualified request collapses
module nios_cpu_index_capture
  import nios_cpu_index_pkg::*;
#(
  parameter int WIDTH       = INDEX_WIDTH,
  parameter int SYNC_STAGES = INDEX_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             src_req,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ack,
  output logic [WIDTH-1:0] index_out,
  output logic             index_updated,
  output logic [7:0]       capture_count,
  output logic             glitch_seen
);

  logic         req_s;
  index_state_t state;
  index_state_t next_state;
  logic         do_capture;
  logic         do_glitch;

  nios_cpu_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (src_req),
    .q       (req_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_capture = 1'b0;
    do_glitch  = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          next_state = QUALIFY;
        end
      end
      QUALIFY: begin
        // src_data is sampled only here: the request has been high for
        // the whole synchronizer depth plus one cycle, so the source's
        // data has long since settled.
        if (req_s) begin
          next_state = HOLD;
          do_capture = 1'b1;
        end else begin
          next_state = IDLE;
          do_glitch  = 1'b1;
        end
      end
      HOLD: begin
        if (!req_s) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // src_ack tracks the HOLD state one edge early so it is a plain flop
  // output rising together with index_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ack       <= 1'b0;
      index_out     <= '0;
      index_updated <= 1'b0;
      capture_count <= 8'd0;
      glitch_seen   <= 1'b0;
    end else begin
      src_ack       <= (next_state == HOLD);
      index_updated <= do_capture;
      if (do_capture) begin
        index_out     <= src_data;
        capture_count <= capture_count + 8'd1;
      end
      if (do_glitch) begin
        glitch_seen <= 1'b1;
      end
    end
  end

endmodule
